ps2_receiver_fifo: RTL and testbench
====================================

PS2_RECEIVER_FIFO -- requirements
Module: ps2_receiver_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of buffered code entries (power of 2, 2..64).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle Clock_50 cycles allowed between PS2 clock edges mid-frame.
REQ-003 SHALL have port Clock_50  input  1  system clock, 50 MHz.
REQ-004 SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port PS2_clock  input  1  asynchronous PS2 device clock.
REQ-006 SHALL have port PS2_data  input  1  asynchronous PS2 device data.
REQ-007 SHALL have port code_read  input  1  pop request for the head entry.
REQ-008 SHALL have port clear_errors  input  1  clears sticky error flags.
REQ-009 SHALL have port code_data  output  8  scan code at FIFO head.
REQ-010 SHALL have port code_make  output  1  head entry is make (1) or break (0).
REQ-011 SHALL have port code_extended  output  1  head entry was E0-prefixed.
REQ-012 SHALL have port code_valid  output  1  FIFO non-empty.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.
REQ-014 SHALL have ports parity_error, framing_error, overflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL pass PS2_clock and PS2_data through two-flop synchronisers; a frame bit is sampled when synchronised clock is 1 and its delayed copy is 0.
REQ-016 SHALL implement FSM IDLE -> DATA (start bit 0 sampled) -> PARITY (after 8th data bit) -> STOP -> IDLE; a start bit of 1 keeps IDLE.
REQ-017 SHALL shift data bits LSB first into an 8-bit register; bit counter 0..7.
REQ-018 SHALL, in any non-IDLE state, return to IDLE, discard the frame and clear prefix flags when TIMEOUT_CYCLES cycles elapse without a sample edge; no flag is raised.
REQ-019 SHALL on stop bit 0 discard the frame, set framing_error and clear prefix flags.
REQ-020 SHALL on valid byte 0xE0 set the extended flag and on 0xF0 set the break flag, without pushing.
REQ-021 SHALL on any other valid byte push {extended, ~break, byte} and clear both prefix flags.
REQ-022 SHALL write the entry on the Clock_50 edge processing the stop bit; code_valid and fifo_count reflect it on the next cycle.
REQ-023 SHALL present the head entry show-ahead on code_data/code_make/code_extended while code_valid=1; value undefined-free (held at last) when empty.
REQ-024 SHALL pop one entry per cycle with code_read=1 and code_valid=1; code_read when empty is ignored.
REQ-025 SHALL on push while full with no pop drop the new entry and set overflow; push and pop in the same cycle while full both succeed, count unchanged.
REQ-026 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-027 SHALL clear sticky flags when clear_errors=1; a new error in the same cycle wins (flag stays 1).

Reset
REQ-028 SHALL on Resetn=0 force FSM IDLE, FIFO empty, prefix flags 0, synchronisers 0, all outputs 0, timeout counter 0.
REQ-029 SHALL abort any in-progress frame on reset with no partial push.

Configuration
REQ-030 SHALL, with PS2_PARITY_CHECK_EN defined, check odd parity over 8 data bits + parity bit, discard failing frames, set parity_error and clear prefix flags.
REQ-031 SHALL, without PS2_PARITY_CHECK_EN, ignore the parity bit and tie parity_error to 0.

Verification
REQ-032 SHALL cover frame 0x1C (parity 0, stop 1) -> one entry code_data=0x1C, code_make=1, code_extended=0, fifo_count=1.
REQ-033 SHALL cover frames F0,1C then E0,F0,75 -> entries {0x1C,make=0,ext=0} then {0x75,make=0,ext=1}.
REQ-034 SHALL cover FIFO_DEPTH+1 frames with no reads -> fifo_count=FIFO_DEPTH, overflow=1, head=first code; pop and push same cycle keeps count.
REQ-035 SHALL cover frame 0x1C with parity 1 (PS2_PARITY_CHECK_EN) -> no push, parity_error=1; clear_errors -> 0.
REQ-036 SHALL cover PS2_clock stalled after 4 data bits for TIMEOUT_CYCLES -> FSM IDLE, next good frame 0x29 received correctly.
REQ-037 SHALL cover Resetn pulse mid-frame and stop bit 0 -> FIFO empty after reset; framing_error=1, no push.

Source files
------------

// File: rtl/ps2_receiver_fifo.sv
// ps2_receiver_fifo
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity, stop),
// folds E0/F0 prefixes into per-entry extended/make flags, and buffers the
// resulting scan codes in a show-ahead FIFO with sticky error flags.
// Optional feature: define PS2_PARITY_CHECK_EN to enable odd-parity checking;
// without it the parity bit is ignored and parity_error is tied to 0.
module ps2_receiver_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          Clock_50,
  input  logic                          Resetn,
  input  logic                          PS2_clock,
  input  logic                          PS2_data,
  input  logic                          code_read,
  input  logic                          clear_errors,
  output logic [7:0]                    code_data,
  output logic                          code_make,
  output logic                          code_extended,
  output logic                          code_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_error,
  output logic                          framing_error,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       make;
    logic [7:0] code;
  } entry_t;

  // Synchroniser chain and edge-detect copy
  logic clk_meta_q, clk_sync_q, clk_dly_q;
  logic dat_meta_q, dat_sync_q;
  logic sample;

  // Frame receiver state
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic             push;
  logic             frame_err;
  logic             parity_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic             par_q, par_d;
  logic             par_err;
  logic             parity_error_q, parity_error_d;
`endif

  // FIFO state
  entry_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             held_q, held_d;
  entry_t             push_entry;
  entry_t             head;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               ovf_new;
  logic               framing_error_q, framing_error_d;
  logic               overflow_q, overflow_d;

  // Two-flop synchronisers plus one delayed copy of the clock for edge detection
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      clk_meta_q <= 1'b0;
      clk_sync_q <= 1'b0;
      clk_dly_q  <= 1'b0;
      dat_meta_q <= 1'b0;
      dat_sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take its neighbour's old value, forming a true chain.
      clk_meta_q <= PS2_clock;
      clk_sync_q <= clk_meta_q;
      clk_dly_q  <= clk_sync_q;
      dat_meta_q <= PS2_data;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign sample = clk_sync_q & ~clk_dly_q;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Frame FSM: next state, shift register, prefix flags, timeout and push request
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    timer_d   = timer_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    push      = 1'b0;
    frame_err = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
    par_err   = 1'b0;
`endif
    if (state_q == ST_IDLE) begin
      timer_d = '0;
      if (sample && !dat_sync_q) begin
        state_d   = ST_DATA;
        bit_cnt_d = 3'd0;
      end
    end else if (sample) begin
      timer_d = '0;
      case (state_q)
        ST_DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_sync_q;
`endif
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (!dat_sync_q) begin
            frame_err = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
          end else if (!parity_ok) begin
`ifdef PS2_PARITY_CHECK_EN
            par_err = 1'b1;
`endif
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      endcase
    end else if (timer_q == TMO_LAST) begin
      // Device went quiet mid-frame: drop the partial frame silently
      state_d = ST_IDLE;
      timer_d = '0;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // Receiver state registers
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      timer_q   <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      timer_q   <= timer_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  assign push_entry = '{ext: ext_q, make: ~brk_q, code: shift_q};

  // FIFO control: pointers, occupancy, last-popped head and sticky flags
  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = code_read && (count_q != '0);
    push_ok  = push && (!full || pop);
    ovf_new  = push && full && !pop;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    held_d   = pop ? mem_q[rd_ptr_q] : held_q;
    framing_error_d = (framing_error_q && !clear_errors) || frame_err;
    overflow_d      = (overflow_q && !clear_errors) || ovf_new;
`ifdef PS2_PARITY_CHECK_EN
    parity_error_d  = (parity_error_q && !clear_errors) || par_err;
`endif
  end

  // FIFO storage write port
  always_ff @(posedge Clock_50) begin
    // NOTE: storage is not reset; a slot is only ever read after it has been written.
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  // FIFO control and error flag registers
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      held_q          <= '0;
      framing_error_q <= 1'b0;
      overflow_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_error_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      held_q          <= held_d;
      framing_error_q <= framing_error_d;
      overflow_q      <= overflow_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_error_q  <= parity_error_d;
`endif
    end
  end

  // Show-ahead head; when empty, hold the last entry popped (0 after reset)
  assign head          = (count_q != '0) ? mem_q[rd_ptr_q] : held_q;
  assign code_data     = head.code;
  assign code_make     = head.make;
  assign code_extended = head.ext;
  assign code_valid    = (count_q != '0);
  assign fifo_count    = count_q;
  assign framing_error = framing_error_q;
  assign overflow      = overflow_q;
`ifdef PS2_PARITY_CHECK_EN
  assign parity_error  = parity_error_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_receiver_fifo.sv
// tb_ps2_receiver_fifo
// Directed bench: bit-bangs PS/2 frames and compares FIFO outputs and error
// flags against hand-computed values.
module tb_ps2_receiver_fifo;

  localparam int DEPTH = 4;
  localparam int TMO   = 200;
  localparam int HALF  = 20;

  logic       Clock_50 = 1'b0;
  logic       Resetn;
  logic       PS2_clock;
  logic       PS2_data;
  logic       code_read;
  logic       clear_errors;
  logic [7:0] code_data;
  logic       code_make;
  logic       code_extended;
  logic       code_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       parity_error;
  logic       framing_error;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  ps2_receiver_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock_50      (Clock_50),
    .Resetn        (Resetn),
    .PS2_clock     (PS2_clock),
    .PS2_data      (PS2_data),
    .code_read     (code_read),
    .clear_errors  (clear_errors),
    .code_data     (code_data),
    .code_make     (code_make),
    .code_extended (code_extended),
    .code_valid    (code_valid),
    .fifo_count    (fifo_count),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overflow      (overflow)
  );

  always #10 Clock_50 = ~Clock_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clock_50);
  endtask

  // One PS/2 bit: data set while clock low, receiver samples on the rising edge.
  // The strobes fire on the exact Clock_50 edge that processes this bit.
  task automatic send_bit(input logic b, input logic pop_here, input logic clr_here);
    PS2_data  = b;
    PS2_clock = 1'b0;
    wait_cycles(HALF);
    PS2_clock = 1'b1;
    if (pop_here || clr_here) begin
      wait_cycles(2);
      code_read    = pop_here;
      clear_errors = clr_here;
      wait_cycles(1);
      code_read    = 1'b0;
      clear_errors = 1'b0;
      wait_cycles(HALF - 3);
    end else begin
      wait_cycles(HALF);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input logic pop_at_stop, input logic clr_at_stop);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, 1'b0);
    send_bit(par, 1'b0, 1'b0);
    send_bit(stop, pop_at_stop, clr_at_stop);
    wait_cycles(5);
  endtask

  task automatic good_frame(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    code_read = 1'b1;
    wait_cycles(1);
    code_read = 1'b0;
    wait_cycles(1);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    wait_cycles(1);
    clear_errors = 1'b0;
    wait_cycles(1);
  endtask

  task automatic check_head(input string tag, input logic [7:0] code,
                            input logic make, input logic ext);
    check({tag, ".data"}, 32'(code_data), 32'(code));
    check({tag, ".make"}, 32'(code_make), 32'(make));
    check({tag, ".ext"},  32'(code_extended), 32'(ext));
  endtask

  // Watchdog: the directed sequence is cycle-deterministic; this only guards a hang
  initial begin
    #5ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] partial;
    Resetn       = 1'b0;
    PS2_clock    = 1'b1;
    PS2_data     = 1'b1;
    code_read    = 1'b0;
    clear_errors = 1'b0;
    wait_cycles(5);
    Resetn = 1'b1;
    wait_cycles(10);

    // Reset state
    check("rst.valid", 32'(code_valid), 32'd0);
    check("rst.count", 32'(fifo_count), 32'd0);
    check("rst.data",  32'(code_data), 32'h00);
    check("rst.flags", {29'd0, parity_error, framing_error, overflow}, 32'd0);

    // Single make code 0x1C
    good_frame(8'h1C);
    check("mk.valid", 32'(code_valid), 32'd1);
    check("mk.count", 32'(fifo_count), 32'd1);
    check_head("mk", 8'h1C, 1'b1, 1'b0);
    pop_one();
    check("mk.pop_count", 32'(fifo_count), 32'd0);
    check("mk.pop_valid", 32'(code_valid), 32'd0);
    check("mk.held", 32'(code_data), 32'h1C);
    code_read = 1'b1;   // read while empty is ignored
    wait_cycles(1);
    code_read = 1'b0;
    wait_cycles(1);
    check("mk.empty_read", 32'(fifo_count), 32'd0);

    // Break and extended-break sequences
    good_frame(8'hF0);
    good_frame(8'h1C);
    good_frame(8'hE0);
    good_frame(8'hF0);
    good_frame(8'h75);
    check("brk.count", 32'(fifo_count), 32'd2);
    check_head("brk1", 8'h1C, 1'b0, 1'b0);
    pop_one();
    check_head("brk2", 8'h75, 1'b0, 1'b1);
    pop_one();

    // Extended make, then a plain make must not inherit the prefix
    good_frame(8'hE0);
    good_frame(8'h74);
    good_frame(8'h1C);
    check("ext.count", 32'(fifo_count), 32'd2);
    check_head("ext1", 8'h74, 1'b1, 1'b1);
    pop_one();
    check_head("ext2", 8'h1C, 1'b1, 1'b0);
    pop_one();

    // Overflow: DEPTH+1 frames, last one dropped
    for (int i = 0; i <= DEPTH; i++) good_frame(8'h10 + 8'(i));
    check("ovf.count", 32'(fifo_count), 32'(DEPTH));
    check("ovf.flag",  32'(overflow), 32'd1);
    check_head("ovf.head", 8'h10, 1'b1, 1'b0);
    pulse_clear();
    check("ovf.clear", 32'(overflow), 32'd0);
    // Push and pop on the same edge while full
    send_frame(8'h20, ~^8'h20, 1'b1, 1'b1, 1'b0);
    check("pp.count", 32'(fifo_count), 32'(DEPTH));
    check("pp.ovf",   32'(overflow), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      check_head("pp.drain", 8'h10 + 8'(i), 1'b1, 1'b0);
      pop_one();
    end
    check_head("pp.last", 8'h20, 1'b1, 1'b0);
    pop_one();
    check("pp.empty", 32'(fifo_count), 32'd0);

    // Parity bit wrong for 0x1C
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("par.count", 32'(fifo_count), 32'd0);
    check("par.flag",  32'(parity_error), 32'd1);
    pulse_clear();
    check("par.clear", 32'(parity_error), 32'd0);
`else
    check("par.count", 32'(fifo_count), 32'd1);
    check("par.flag",  32'(parity_error), 32'd0);
    check_head("par", 8'h1C, 1'b1, 1'b0);
    pop_one();
`endif

    // Timeout: stall after 4 data bits, then a clean frame
    partial = 8'h5A;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i], 1'b0, 1'b0);
    wait_cycles(TMO + 100);
    good_frame(8'h29);
    check("tmo.count", 32'(fifo_count), 32'd1);
    check_head("tmo", 8'h29, 1'b1, 1'b0);
    check("tmo.flags", {29'd0, parity_error, framing_error, overflow}, 32'd0);

    // Reset mid-frame with an entry held and an F0 prefix pending
    good_frame(8'hF0);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(partial[i], 1'b0, 1'b0);
    Resetn = 1'b0;
    wait_cycles(3);
    Resetn = 1'b1;
    wait_cycles(10);
    check("mrst.count", 32'(fifo_count), 32'd0);
    check("mrst.valid", 32'(code_valid), 32'd0);
    check("mrst.data",  32'(code_data), 32'h00);
    good_frame(8'h33);
    check_head("mrst.next", 8'h33, 1'b1, 1'b0);
    pop_one();

    // Stop bit 0
    send_frame(8'h1C, ~^8'h1C, 1'b0, 1'b0, 1'b0);
    check("frm.count", 32'(fifo_count), 32'd0);
    check("frm.flag",  32'(framing_error), 32'd1);
    pulse_clear();
    check("frm.clear", 32'(framing_error), 32'd0);
    // New error on the same edge as clear_errors: error wins
    send_frame(8'h1C, ~^8'h1C, 1'b0, 1'b0, 1'b1);
    check("frm.win", 32'(framing_error), 32'd1);
    check("frm.win_count", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
